// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO byte reader:
//   DataWidthDefault - default FIFO word width in bits
//   bytes_per_word() - bytes emitted per popped word
//   byte_idx_width() - width of the byte index register (never below 1 bit)
//   state_t          - reader state: IDLE (no word held) / SEND (bytes pending)
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DataWidthDefault = 32;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  // A one-byte word still needs a (constant-zero) index register.
  function automatic int byte_idx_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/fifo_byte_reader_if.sv
// -----------------------------------------------------------------------------
// fifo_byte_reader_if
// Bundles the FIFO read side and the byte stream side of the reader.
//   empty     - FIFO empty flag (from FIFO)
//   readData  - FIFO head word, first-word-fall-through (from FIFO)
//   readEn    - FIFO pop strobe (from reader)
//   outValid  - output byte valid (from reader)
//   outReady  - downstream accepts byte (from sink)
//   outData   - current output byte (from reader)
//   outLast   - final byte of the current word (from reader)
//   wordCnt   - words popped, modulo 2^16 (from reader)
// Modports: master = the reader itself, slave = its environment.
// -----------------------------------------------------------------------------
interface fifo_byte_reader_if
  import fifo_pkg::*;
#(
  parameter int DataWidth = DataWidthDefault
);

  logic                 empty;
  logic [DataWidth-1:0] readData;
  logic                 readEn;
  logic                 outValid;
  logic                 outReady;
  logic [7:0]           outData;
  logic                 outLast;
  logic [15:0]          wordCnt;

  modport master (
    input  empty,
    input  readData,
    input  outReady,
    output readEn,
    output outValid,
    output outData,
    output outLast,
    output wordCnt
  );

  modport slave (
    output empty,
    output readData,
    output outReady,
    input  readEn,
    input  outValid,
    input  outData,
    input  outLast,
    input  wordCnt
  );

endinterface

// File: rtl/fifo_byte_reader.sv
// -----------------------------------------------------------------------------
// fifo_byte_reader
// Pops words from a first-word-fall-through FIFO and streams them out one byte
// per handshake, least-significant byte first. A new word is popped in the
// same cycle as the last-byte handshake when the FIFO is not empty, so with
// outReady held high the stream runs at one byte per cycle with no bubbles.
// Ports:
//   clk - sole clock, rising edge
//   rst - asynchronous, active-high reset; drops any partially sent word
//   bus - fifo_byte_reader_if.master (FIFO read side + byte stream + wordCnt)
// -----------------------------------------------------------------------------
module fifo_byte_reader
  import fifo_pkg::*;
#(
  parameter int DataWidth    = DataWidthDefault,
  parameter int BytesPerWord = bytes_per_word(DataWidth)
) (
  input  logic                clk,
  input  logic                rst,
  fifo_byte_reader_if.master  bus
);

  localparam int              IdxW    = byte_idx_width(BytesPerWord);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(BytesPerWord - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [IdxW-1:0]      r_byte_idx;
  logic [IdxW-1:0]      w_byte_idx_next;
  logic [DataWidth-1:0] r_hold;
  logic [DataWidth-1:0] w_hold_next;
  logic [15:0]          r_word_cnt;
  logic [15:0]          w_word_cnt_next;

  logic w_out_valid;
  logic w_last;
  logic w_handshake;
  logic w_pop;

  assign w_out_valid = (r_state == SEND);
  assign w_last      = w_out_valid && (r_byte_idx == LastIdx);
  assign w_handshake = w_out_valid && bus.outReady;

  // Pop when nothing is held, or when the last byte is leaving this cycle.
  // rst gates the strobe combinationally so the FIFO is never popped while
  // the reader is held in reset.
  assign w_pop = !rst && !bus.empty &&
                 ((r_state == IDLE) || (w_handshake && w_last));

  // Next-state / datapath process
  always_comb begin
    w_state_next    = r_state;
    w_byte_idx_next = r_byte_idx;
    w_hold_next     = r_hold;
    w_word_cnt_next = r_word_cnt;

    if (w_pop) begin
      // Covers both the fill from IDLE and the back-to-back refill.
      w_state_next    = SEND;
      w_byte_idx_next = '0;
      w_hold_next     = bus.readData;
      w_word_cnt_next = r_word_cnt + 16'd1;
    end else if (w_handshake) begin
      if (w_last) begin
        w_state_next    = IDLE;
        w_byte_idx_next = '0;
      end else begin
        w_byte_idx_next = r_byte_idx + IdxW'(1);
      end
    end
  end

  // State register process
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_byte_idx <= '0;
      r_hold     <= '0;
      r_word_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_byte_idx <= w_byte_idx_next;
      r_hold     <= w_hold_next;
      r_word_cnt <= w_word_cnt_next;
    end
  end

  // Byte select straight off the hold register. A one-byte word has nothing
  // to select, so it bypasses the part-select.
  generate
    if (BytesPerWord == 1) begin : g_single_byte
      assign bus.outData = r_hold[7:0];
    end else begin : g_multi_byte
      assign bus.outData = r_hold[{r_byte_idx, 3'b000} +: 8];
    end
  endgenerate

  assign bus.readEn   = w_pop;
  assign bus.outValid = w_out_valid;
  assign bus.outLast  = w_last;
  assign bus.wordCnt  = r_word_cnt;

endmodule

// File: doc/fifo_byte_reader.md
FIFO_BYTE_READER -- requirements
Module: fifo_byte_reader

Interface
REQ-001 SHALL have parameter DataWidth, default 32, FIFO word width; multiple of 8, at least 8.
REQ-002 SHALL have derived parameter BytesPerWord, default DataWidth/8, number of bytes emitted per popped word.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port empty  input  1  FIFO empty flag.
REQ-006 SHALL have port readData  input  DataWidth  FIFO head word; first-word-fall-through, valid in the same cycle as readEn.
REQ-007 SHALL have port readEn  output  1  FIFO pop strobe.
REQ-008 SHALL have port outValid  output  1  output byte valid.
REQ-009 SHALL have port outReady  input  1  downstream accepts byte.
REQ-010 SHALL have port outData  output  8  current output byte.
REQ-011 SHALL have port outLast  output  1  marks the final byte of a word.
REQ-012 SHALL have port wordCnt  output  16  count of words popped; wraps modulo 2^16.

Function
REQ-013 SHALL implement two states: IDLE (no word held) and SEND (word held, bytes pending).
REQ-014 SHALL assert readEn combinationally when rst=0, empty=0, and either (state=IDLE) or (state=SEND, outValid=1, outReady=1, byteIdx=BytesPerWord-1).
REQ-015 SHALL never assert readEn while empty=1 or rst=1.
REQ-016 SHALL, on a cycle with readEn=1, capture readData into the hold register, set byteIdx=0, enter or stay in SEND, and increment wordCnt by 1.
REQ-017 SHALL drive outValid=1 exactly when state=SEND.
REQ-018 SHALL drive outData = hold[8*byteIdx +: 8], least-significant byte first.
REQ-019 SHALL hold outData and outLast stable while outValid=1 and outReady=0.
REQ-020 SHALL increment byteIdx on a handshake (outValid and outReady) when byteIdx<BytesPerWord-1.
REQ-021 SHALL drive outLast=1 exactly when outValid=1 and byteIdx=BytesPerWord-1.
REQ-022 SHALL return to IDLE after a last-byte handshake while empty=1.
REQ-023 SHALL refill back-to-back after a last-byte handshake while empty=0: pop in the same cycle, with no idle bubble.
REQ-024 SHALL give a latency of 1 cycle from readEn to the first outValid.
REQ-025 SHALL, with outReady held at 1, sustain throughput of 1 byte per cycle.
REQ-026 SHALL have byteIdx width $clog2(BytesPerWord), minimum 1 bit.
REQ-027 SHALL wrap wordCnt from 0xFFFF to 0x0000 without a flag.

Reset
REQ-028 SHALL, while rst=1, force: state=IDLE, byteIdx=0, hold=0, wordCnt=0, outValid=0, outLast=0, outData=0x00, readEn=0.
REQ-029 SHALL, on rst asserted mid-word, discard the remaining bytes of the held word; no replay after reset.
REQ-030 SHALL make the first pop possible in the first clock edge after rst deasserts, if empty=0.

Structure
REQ-031 SHALL place the following in shared package fifo_pkg: the DataWidth default, BytesPerWord derivation, and the state enum (IDLE, SEND).
REQ-032 SHALL be a single module with no sub-module; the byte select is an indexed part-select, not a separate mux block.

Verification
REQ-033 SHALL cover single word: empty=0 with readData=0x44332211 for one pop, outReady=1 -> readEn pulse at cycle 0; outData 0x11,0x22,0x33,0x44 on cycles 1-4; outLast only with 0x44; wordCnt=1; IDLE at cycle 5.
REQ-034 SHALL cover back-to-back: two words 0x04030201 then 0x08070605, outReady=1 -> 8 consecutive valid bytes 01..08; readEn at cycles 0 and 4; no bubble.
REQ-035 SHALL cover backpressure: outReady=0 for 3 cycles while outData=0x33 -> outData stays 0x33 and byteIdx stays 2; no readEn; resumes with 0x44 after outReady=1.
REQ-036 SHALL cover empty FIFO: empty=1 for 20 cycles -> readEn=0 and outValid=0 throughout; wordCnt unchanged.
REQ-037 SHALL cover reset mid-word: rst pulse after byte 0x22 -> all outputs 0 during rst; after release with empty=0, the next word begins at its byte 0; wordCnt restarts from 0 and reads 1.
REQ-038 SHALL cover wrap: preload 65535 pops, then one more pop -> wordCnt=0x0000.
